wbu_commit_stage: RTL and testbench

- Parametrised write-back/commit stage, placed after the load/store unit and feeding the register file.
- Holds one registered entry from LSU behind a valid/ready handshake.
- Performs load-data alignment and sign/zero extension, then drives the register-file write port.
- Counts retired instructions; a halt FSM stops the pipeline on ebreak or an unsupported instruction.

---
 rtl/wbu_commit_stage_pkg.sv | 36 +++
 rtl/wbu_load_ext.sv | 47 ++++
 rtl/wbu_commit_stage.sv | 142 ++++++++++++++
 tb/tb_wbu_commit_stage.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbu_commit_stage_pkg.sv
// Shared encodings and defaults for the write-back / commit stage.
package wbu_commit_stage_pkg;

    localparam int unsigned XLEN_DEF   = 32;
    localparam int unsigned REG_AW_DEF = 5;
    localparam int unsigned OFS_W_DEF  = 2;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        HR_NONE    = 2'd0,
        HR_EBREAK  = 2'd1,
        HR_ILLEGAL = 2'd2
    } halt_reason_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    // Width-independent control part of the held entry.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        inst_valid;
        logic        ebreak;
        logic        rf_we;
        logic        load;
        logic [1:0]  size;
        logic        is_unsigned;
    } entry_ctl_t;

endpackage

// File: rtl/wbu_load_ext.sv
// Combinational load-data alignment and sign/zero extension.
module wbu_load_ext
    import wbu_commit_stage_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned OFS_W = OFS_W_DEF
) (
    input  logic [XLEN-1:0]  rdata,
    input  logic [OFS_W-1:0] addr_lo,
    input  logic [1:0]       size,
    input  logic             is_unsigned,
    output logic [XLEN-1:0]  data_c
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic            sign;

    // Bytes shifted past the top fill with zero.
    assign shifted = rdata >> {addr_lo, 3'b000};

    // Dword on a 32-bit datapath falls into the default: a full-width pass.
    always_comb begin
        mask = '1;
        sign = shifted[XLEN-1];
        case (size)
            SZ_B: begin
                mask = XLEN'(8'hFF);
                sign = shifted[7];
            end
            SZ_H: begin
                mask = XLEN'(16'hFFFF);
                sign = shifted[15];
            end
            SZ_W: begin
                mask = XLEN'(32'hFFFF_FFFF);
                sign = shifted[31];
            end
            default: begin
                mask = '1;
                sign = shifted[XLEN-1];
            end
        endcase
        data_c = (shifted & mask) | ((sign && !is_unsigned) ? ~mask : '0);
    end

endmodule

// File: rtl/wbu_commit_stage.sv
// Write-back / commit stage: one-entry holding register, load extension,
// register-file write, retire counter and RUN/HALT control.
module wbu_commit_stage
    import wbu_commit_stage_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF,
    parameter int unsigned OFS_W  = OFS_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ls_valid,
    output logic              ls_ready,
    input  logic [31:0]       ls_pc,
    input  logic [31:0]       ls_inst,
    input  logic              ls_inst_valid,
    input  logic              ls_ebreak,
    input  logic              ls_rf_we,
    input  logic [REG_AW-1:0] ls_rd,
    input  logic [XLEN-1:0]   ls_alu_res,
    input  logic              ls_load,
    input  logic [1:0]        ls_size,
    input  logic              ls_unsigned,
    input  logic [XLEN-1:0]   ls_dm_rdata,
    input  logic [OFS_W-1:0]  ls_addr_lo,
    input  logic              wb_stall,
    output logic              wb_rf_we,
    output logic [REG_AW-1:0] wb_rf_waddr,
    output logic [XLEN-1:0]   wb_rf_wdata,
    output logic              commit_valid,
    output logic [31:0]       commit_pc,
    output logic [31:0]       commit_inst,
    output logic              halted,
    output logic [1:0]        halt_reason,
    output logic [63:0]       retired_cnt
);

    state_e            state_q, state_d;
    halt_reason_e      reason_q, reason_d;
    logic              full_q;
    entry_ctl_t        ctl_q;
    logic [REG_AW-1:0] rd_q;
    logic [XLEN-1:0]   alu_q;
    logic [XLEN-1:0]   rdata_q;
    logic [OFS_W-1:0]  ofs_q;
    logic [XLEN-1:0]   load_data;
    logic              accept;
    logic              retire;
    logic              commit;
    logic              halt_go;

    wbu_load_ext #(
        .XLEN  (XLEN),
        .OFS_W (OFS_W)
    ) u_load_ext (
        .rdata       (rdata_q),
        .addr_lo     (ofs_q),
        .size        (ctl_q.size),
        .is_unsigned (ctl_q.is_unsigned),
        .data_c      (load_data)
    );

    // Ready is held low while reset is asserted so every output reads 0.
    assign ls_ready = rst_n && (state_q == ST_RUN) && !(full_q && wb_stall);
    assign accept   = ls_valid && ls_ready;
    assign retire   = full_q && !wb_stall && (state_q == ST_RUN);
    assign commit   = retire && (ctl_q.inst != 32'd0);
    assign halt_go  = (state_q == ST_RUN) && (state_d == ST_HALT);

    assign wb_rf_we     = commit && ctl_q.rf_we && (rd_q != '0);
    assign wb_rf_waddr  = rd_q;
    assign wb_rf_wdata  = ctl_q.load ? load_data : alu_q;
    assign commit_valid = commit;
    assign commit_pc    = ctl_q.pc;
    assign commit_inst  = ctl_q.inst;
    assign halted       = (state_q == ST_HALT);
    assign halt_reason  = reason_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            reason_q <= HR_NONE;
        end else begin
            state_q  <= state_d;
            reason_q <= reason_d;
        end
    end

    // Halt on a retiring ebreak first, then on an unrecognised instruction.
    always_comb begin
        state_d  = state_q;
        reason_d = reason_q;
        if (state_q == ST_RUN && commit) begin
            if (ctl_q.ebreak) begin
                state_d  = ST_HALT;
                reason_d = HR_EBREAK;
            end else if (!ctl_q.inst_valid) begin
                state_d  = ST_HALT;
                reason_d = HR_ILLEGAL;
            end
        end
    end

    // Entry register: an accept overwrites, a retire alone drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q  <= 1'b0;
            ctl_q   <= '0;
            rd_q    <= '0;
            alu_q   <= '0;
            rdata_q <= '0;
            ofs_q   <= '0;
        end else if (halt_go || state_q == ST_HALT) begin
            full_q <= 1'b0;
        end else if (accept) begin
            full_q            <= 1'b1;
            ctl_q.pc          <= ls_pc;
            ctl_q.inst        <= ls_inst;
            ctl_q.inst_valid  <= ls_inst_valid;
            ctl_q.ebreak      <= ls_ebreak;
            ctl_q.rf_we       <= ls_rf_we;
            ctl_q.load        <= ls_load;
            ctl_q.size        <= ls_size;
            ctl_q.is_unsigned <= ls_unsigned;
            rd_q              <= ls_rd;
            alu_q             <= ls_alu_res;
            rdata_q           <= ls_dm_rdata;
            ofs_q             <= ls_addr_lo;
        end else if (retire) begin
            full_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= 64'd0;
        end else if (commit) begin
            retired_cnt <= retired_cnt + 64'd1;
        end
    end

endmodule

// File: tb/tb_wbu_commit_stage.sv
// Randomised and directed bench for wbu_commit_stage against a transaction-level model.
module tb_wbu_commit_stage;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          inst_valid;
        bit          ebreak;
        bit          rf_we;
        logic [4:0]  rd;
        logic [31:0] alu;
        bit          load;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] rdata;
        logic [1:0]  ofs;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ls_valid, ls_ready;
    logic [31:0] ls_pc, ls_inst;
    logic        ls_inst_valid, ls_ebreak, ls_rf_we;
    logic [4:0]  ls_rd;
    logic [31:0] ls_alu_res;
    logic        ls_load;
    logic [1:0]  ls_size;
    logic        ls_unsigned;
    logic [31:0] ls_dm_rdata;
    logic [1:0]  ls_addr_lo;
    logic        wb_stall;
    logic        wb_rf_we;
    logic [4:0]  wb_rf_waddr;
    logic [31:0] wb_rf_wdata;
    logic        commit_valid;
    logic [31:0] commit_pc, commit_inst;
    logic        halted;
    logic [1:0]  halt_reason;
    logic [63:0] retired_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: in-flight instructions, halt status and retire count.
    txn_t            q[$];
    bit              m_halted;
    logic [1:0]      m_reason;
    longint unsigned m_cnt;

    // Snapshot of DUT outputs from the most recent cycle's sample point.
    logic        o_ready, o_commit, o_we, o_halted;
    logic [4:0]  o_waddr;
    logic [31:0] o_wdata, o_pc;
    logic [1:0]  o_reason;
    logic [63:0] o_cnt;

    wbu_commit_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ls_valid      (ls_valid),
        .ls_ready      (ls_ready),
        .ls_pc         (ls_pc),
        .ls_inst       (ls_inst),
        .ls_inst_valid (ls_inst_valid),
        .ls_ebreak     (ls_ebreak),
        .ls_rf_we      (ls_rf_we),
        .ls_rd         (ls_rd),
        .ls_alu_res    (ls_alu_res),
        .ls_load       (ls_load),
        .ls_size       (ls_size),
        .ls_unsigned   (ls_unsigned),
        .ls_dm_rdata   (ls_dm_rdata),
        .ls_addr_lo    (ls_addr_lo),
        .wb_stall      (wb_stall),
        .wb_rf_we      (wb_rf_we),
        .wb_rf_waddr   (wb_rf_waddr),
        .wb_rf_wdata   (wb_rf_wdata),
        .commit_valid  (commit_valid),
        .commit_pc     (commit_pc),
        .commit_inst   (commit_inst),
        .halted        (halted),
        .halt_reason   (halt_reason),
        .retired_cnt   (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Load result from the arithmetic definition: shift, truncate, reinterpret sign.
    function automatic logic [31:0] model_load(input txn_t t);
        longint unsigned sh, v;
        int bits;
        sh   = 64'(t.rdata) >> (int'(t.ofs) * 8);
        bits = (t.size == 2'd0) ? 8 : (t.size == 2'd1) ? 16 : 32;
        if (bits == 32) return sh[31:0];
        v = sh % (64'd1 << bits);
        if (!t.uns && v >= (64'd1 << (bits - 1)))
            v = v + (64'd1 << 32) - (64'd1 << bits);
        return v[31:0];
    endfunction

    function automatic txn_t idle_txn();
        txn_t t;
        t = '{pc: 0, inst: 0, inst_valid: 0, ebreak: 0, rf_we: 0, rd: 0, alu: 0,
              load: 0, size: 0, uns: 0, rdata: 0, ofs: 0};
        return t;
    endfunction

    function automatic txn_t alu_txn(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] res);
        txn_t t;
        t = idle_txn();
        t.pc = pc; t.inst = 32'h0000_0033 | {20'd0, rd, 7'd0}; t.inst_valid = 1;
        t.rf_we = 1; t.rd = rd; t.alu = res;
        return t;
    endfunction

    function automatic txn_t load_txn(input logic [4:0] rd, input logic [1:0] size, input bit uns,
                                      input logic [1:0] ofs, input logic [31:0] rdata);
        txn_t t;
        t = alu_txn(32'h0000_1000, rd, 32'hDEAD_DEAD);
        t.inst = 32'h0000_0003; t.load = 1; t.size = size; t.uns = uns; t.ofs = ofs; t.rdata = rdata;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.pc         = $urandom;
        t.inst       = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom | 32'd1);
        t.inst_valid = 1;
        t.ebreak     = 0;
        t.rf_we      = ($urandom_range(0, 3) != 0);
        t.rd         = 5'($urandom_range(0, 31));
        t.alu        = $urandom;
        t.load       = 1'($urandom_range(0, 1));
        t.size       = 2'($urandom_range(0, 3));
        t.uns        = 1'($urandom_range(0, 1));
        t.rdata      = $urandom;
        t.ofs        = 2'($urandom_range(0, 3));
        return t;
    endfunction

    // One clock: drive, sample at negedge and compare with model, then advance model.
    task automatic cycle(input txn_t t, input bit v, input bit st);
        bit exp_ready, ret, exp_commit, exp_we;
        ls_valid = v; wb_stall = st;
        ls_pc = t.pc; ls_inst = t.inst; ls_inst_valid = t.inst_valid; ls_ebreak = t.ebreak;
        ls_rf_we = t.rf_we; ls_rd = t.rd; ls_alu_res = t.alu; ls_load = t.load;
        ls_size = t.size; ls_unsigned = t.uns; ls_dm_rdata = t.rdata; ls_addr_lo = t.ofs;
        @(negedge clk);
        exp_ready  = !m_halted && !(q.size() != 0 && st);
        ret        = (q.size() != 0) && !st && !m_halted;
        exp_commit = ret && (q[0].inst != 32'd0);
        exp_we     = exp_commit && q[0].rf_we && (q[0].rd != 5'd0);
        o_ready = ls_ready; o_commit = commit_valid; o_we = wb_rf_we; o_waddr = wb_rf_waddr;
        o_wdata = wb_rf_wdata; o_pc = commit_pc; o_halted = halted; o_reason = halt_reason;
        o_cnt = retired_cnt;
        check("ls_ready", 64'(o_ready), 64'(exp_ready));
        check("commit_valid", 64'(o_commit), 64'(exp_commit));
        check("wb_rf_we", 64'(o_we), 64'(exp_we));
        check("halted", 64'(o_halted), 64'(m_halted));
        check("halt_reason", 64'(o_reason), 64'(m_reason));
        check("retired_cnt", o_cnt, m_cnt);
        if (exp_commit) begin
            check("commit_pc", 64'(o_pc), 64'(q[0].pc));
            check("commit_inst", 64'(commit_inst), 64'(q[0].inst));
        end
        if (exp_we) begin
            check("wb_rf_waddr", 64'(o_waddr), 64'(q[0].rd));
            check("wb_rf_wdata", 64'(o_wdata), 64'(q[0].load ? model_load(q[0]) : q[0].alu));
        end
        @(posedge clk);
        if (exp_commit) begin
            m_cnt++;
            if (q[0].ebreak) begin
                m_halted = 1; m_reason = 2'd1;
            end else if (!q[0].inst_valid) begin
                m_halted = 1; m_reason = 2'd2;
            end
        end
        if (ret) void'(q.pop_front());
        if (m_halted) q.delete();
        else if (v && exp_ready) q.push_back(t);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(ls_ready), 64'd0);
        check({tag, "_we"}, 64'(wb_rf_we), 64'd0);
        check({tag, "_waddr"}, 64'(wb_rf_waddr), 64'd0);
        check({tag, "_wdata"}, 64'(wb_rf_wdata), 64'd0);
        check({tag, "_commit"}, 64'(commit_valid), 64'd0);
        check({tag, "_pc"}, 64'(commit_pc), 64'd0);
        check({tag, "_inst"}, 64'(commit_inst), 64'd0);
        check({tag, "_halted"}, 64'(halted), 64'd0);
        check({tag, "_reason"}, 64'(halt_reason), 64'd0);
        check({tag, "_cnt"}, retired_cnt, 64'd0);
    endtask

    // Asynchronous reset pulse; leaves the bench 1 time unit after a posedge.
    task automatic do_reset(input string tag);
        ls_valid = 0; wb_stall = 0;
        #2 rst_n = 0;
        #1 check_reset_outputs(tag);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        q.delete(); m_halted = 0; m_reason = 0; m_cnt = 0;
        #1 check({tag, "_ready_after"}, 64'(ls_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        txn_t t;
        longint unsigned c0;
        rst_n = 0;
        t = idle_txn();
        ls_valid = 0; wb_stall = 0;
        ls_pc = 0; ls_inst = 0; ls_inst_valid = 0; ls_ebreak = 0; ls_rf_we = 0; ls_rd = 0;
        ls_alu_res = 0; ls_load = 0; ls_size = 0; ls_unsigned = 0; ls_dm_rdata = 0; ls_addr_lo = 0;
        do_reset("por");

        // Signed byte from the top lane.
        cycle(load_txn(5'd5, 2'd0, 0, 2'd3, 32'h8000_0000), 1, 0);
        cycle(idle_txn(), 0, 0);
        check("lb_we", 64'(o_we), 64'd1);
        check("lb_waddr", 64'(o_waddr), 64'd5);
        check("lb_wdata", 64'(o_wdata), 64'hFFFF_FF80);
        check("lb_cnt_pre", o_cnt, 64'd0);
        cycle(idle_txn(), 0, 0);
        check("lb_cnt_post", o_cnt, 64'd1);

        // Unsigned then signed halfword, back to back.
        cycle(load_txn(5'd7, 2'd1, 1, 2'd2, 32'hBEEF_1234), 1, 0);
        cycle(load_txn(5'd8, 2'd1, 0, 2'd2, 32'hBEEF_1234), 1, 0);
        check("lhu_wdata", 64'(o_wdata), 64'h0000_BEEF);
        cycle(idle_txn(), 0, 0);
        check("lh_wdata", 64'(o_wdata), 64'hFFFF_BEEF);

        // Three ALU ops with a two-cycle stall on the second.
        c0 = m_cnt;
        cycle(alu_txn(32'h100, 5'd1, 32'h11), 1, 0);
        cycle(alu_txn(32'h104, 5'd2, 32'h22), 1, 0);
        t = alu_txn(32'h108, 5'd3, 32'h33);
        cycle(t, 1, 1);
        check("stall1_ready", 64'(o_ready), 64'd0);
        check("stall1_commit", 64'(o_commit), 64'd0);
        cycle(t, 1, 1);
        check("stall2_ready", 64'(o_ready), 64'd0);
        check("stall2_commit", 64'(o_commit), 64'd0);
        cycle(t, 1, 0);
        check("release_pc", 64'(o_pc), 64'h104);
        cycle(idle_txn(), 0, 0);
        check("third_pc", 64'(o_pc), 64'h108);
        cycle(idle_txn(), 0, 0);
        check("three_cnt", o_cnt, c0 + 3);

        // rd=0 write is suppressed but still retires; a bubble does neither.
        cycle(alu_txn(32'h200, 5'd0, 32'h1234), 1, 0);
        cycle(idle_txn(), 1, 0);
        check("rd0_commit", 64'(o_commit), 64'd1);
        check("rd0_we", 64'(o_we), 64'd0);
        c0 = o_cnt;
        cycle(idle_txn(), 0, 0);
        check("bubble_commit", 64'(o_commit), 64'd0);
        check("rd0_cnt", o_cnt, c0 + 1);
        cycle(idle_txn(), 0, 0);
        check("bubble_cnt", o_cnt, c0 + 1);

        for (int i = 0; i < 400; i++)
            cycle(rand_txn(), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
        cycle(idle_txn(), 0, 0);

        // Ebreak retires, then the stage halts and ignores further traffic.
        t = alu_txn(32'h8000_0010, 5'd0, 32'd0);
        t.inst = 32'h0010_0073; t.ebreak = 1; t.rf_we = 0;
        cycle(t, 1, 0);
        cycle(rand_txn(), 1, 0);
        check("ebreak_commit", 64'(o_commit), 64'd1);
        check("ebreak_pc", 64'(o_pc), 64'h8000_0010);
        cycle(rand_txn(), 1, 0);
        check("ebreak_halted", 64'(o_halted), 64'd1);
        check("ebreak_reason", 64'(o_reason), 64'd1);
        check("ebreak_ready", 64'(o_ready), 64'd0);
        for (int i = 0; i < 5; i++) cycle(rand_txn(), 1, 0);
        check("halt_no_commit", 64'(o_commit), 64'd0);

        // Unsupported instruction halts with reason 2; reset recovers.
        do_reset("rst1");
        t = alu_txn(32'h300, 5'd4, 32'h44);
        t.inst = 32'hFFFF_FFFF; t.inst_valid = 0;
        cycle(t, 1, 0);
        cycle(idle_txn(), 0, 0);
        check("illegal_commit", 64'(o_commit), 64'd1);
        cycle(idle_txn(), 1, 0);
        check("illegal_reason", 64'(o_reason), 64'd2);
        check("illegal_halted", 64'(o_halted), 64'd1);
        do_reset("rst2");
        cycle(alu_txn(32'h400, 5'd9, 32'h99), 1, 0);
        cycle(idle_txn(), 0, 0);
        check("post_reset_commit", 64'(o_commit), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
